// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder for the IF fetch handshake
// One fetch outstanding at a time, fixed wait states, plus a write-only preload port.
module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [31:0]   addr_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic [31:0]   rd_addr;
  logic          rd_bad;
  logic [AW-1:0] rd_idx;
  logic          ld_ok;

  assign req_ready = (state == S_IDLE) && !ld_en;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == S_RESP);

  // With zero wait states the read happens on the accept edge, before addr_q is loaded.
  assign rd_addr    = (state == S_IDLE) ? req_addr : addr_q;
  assign rd_bad     = (rd_addr[1:0] != 2'b00) ||
                      ({2'b00, rd_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign rd_idx     = rd_addr[AW+1:2];
  assign enter_resp = ((state == S_IDLE) && accept && (WAIT_STATES == 0)) ||
                      ((state == S_WAIT) && (cnt == 4'd1));

  assign ld_ok = ({2'b00, ld_addr[31:2]} < 32'(DEPTH_WORDS));

  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) begin
      mem[ld_addr[AW+1:2]] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      addr_q    <= 32'd0;
      rsp_instr <= NOP_WORD;
      rsp_err   <= 1'b0;
    end else begin
      if (enter_resp) begin
        rsp_err   <= rd_bad;
        rsp_instr <= rd_bad ? NOP_WORD : mem[rd_idx];
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q <= req_addr;
            cnt    <= 4'(WAIT_STATES);
            state  <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
